// File: rtl/ram_bist.sv
// RAM built-in self test: writes seed+i to base+i for N words, then reads them back
// and compares each word against its expected value through a LAT-deep expect pipeline.
module ram_bist #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int OUTPUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  read_req,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  write_req,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data
);

  localparam int LAT = 1 + OUTPUT_REG;
  localparam int CW  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0] base_l;
  logic [CW-1:0]         num_l;
  logic [DATA_WIDTH-1:0] seed_l;
  logic [DATA_WIDTH-1:0] read_exp, read_exp_nxt;

  logic                  busy_nxt, done_nxt, pass_nxt;
  logic [15:0]           err_nxt;
  logic [ADDR_WIDTH-1:0] fea_nxt;
  logic                  rd_req_nxt, wr_req_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt, wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;

  logic [LAT-1:0]        cmp_vld_p;
  logic [DATA_WIDTH-1:0] cmp_exp_p  [LAT];
  logic [ADDR_WIDTH-1:0] cmp_addr_p [LAT];
  logic                  mismatch;

  function automatic logic [ADDR_WIDTH-1:0] addr_at(input logic [ADDR_WIDTH-1:0] b,
                                                    input logic [CW-1:0] i);
    return b + i[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] data_at(input logic [DATA_WIDTH-1:0] s,
                                                    input logic [CW-1:0] i);
    return s + DATA_WIDTH'(i);
  endfunction

  assign mismatch = cmp_vld_p[LAT-1] && (read_data != cmp_exp_p[LAT-1]);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    done_nxt     = 1'b0;
    pass_nxt     = pass;
    err_nxt      = err_count;
    fea_nxt      = first_err_addr;
    rd_req_nxt   = 1'b0;
    rd_addr_nxt  = '0;
    read_exp_nxt = '0;
    wr_req_nxt   = 1'b0;
    wr_addr_nxt  = '0;
    wr_data_nxt  = '0;

    if (mismatch) begin
      if (err_count != 16'hFFFF) err_nxt = err_count + 16'd1;
      if (err_count == 16'd0)    fea_nxt = cmp_addr_p[LAT-1];
    end

    case (state)
      IDLE: begin
        if (start) begin
          err_nxt  = '0;
          fea_nxt  = '0;
          pass_nxt = 1'b0;
          cnt_nxt  = '0;
          if (num_words == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b1;
          end else begin
            state_nxt   = WRITE;
            wr_req_nxt  = 1'b1;
            wr_addr_nxt = base_addr;
            wr_data_nxt = seed;
          end
        end
      end
      WRITE: begin
        if (cnt == num_l - 1'b1) begin
          state_nxt    = READ;
          cnt_nxt      = '0;
          rd_req_nxt   = 1'b1;
          rd_addr_nxt  = base_l;
          read_exp_nxt = seed_l;
        end else begin
          cnt_nxt     = cnt + 1'b1;
          wr_req_nxt  = 1'b1;
          wr_addr_nxt = addr_at(base_l, cnt_nxt);
          wr_data_nxt = data_at(seed_l, cnt_nxt);
        end
      end
      READ: begin
        if (cnt == num_l - 1'b1) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt      = cnt + 1'b1;
          rd_req_nxt   = 1'b1;
          rd_addr_nxt  = addr_at(base_l, cnt_nxt);
          read_exp_nxt = data_at(seed_l, cnt_nxt);
        end
      end
      DRAIN: begin
        // The last compare lands in the final drain cycle, so pass sees it via err_nxt.
        if (cnt == CW'(LAT - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == 16'd0);
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      read_req       <= 1'b0;
      read_addr      <= '0;
      read_exp       <= '0;
      write_req      <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      err_count      <= err_nxt;
      first_err_addr <= fea_nxt;
      read_req       <= rd_req_nxt;
      read_addr      <= rd_addr_nxt;
      read_exp       <= read_exp_nxt;
      write_req      <= wr_req_nxt;
      write_addr     <= wr_addr_nxt;
      write_data     <= wr_data_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_l <= base_addr;
      num_l  <= num_words;
      seed_l <= seed;
    end
  end

  // Compare pipeline: stage 0 loads on the edge the RAM samples the read request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_vld_p <= '0;
      for (int s = 0; s < LAT; s++) begin
        cmp_exp_p[s]  <= '0;
        cmp_addr_p[s] <= '0;
      end
    end else begin
      cmp_vld_p[0]  <= read_req;
      cmp_exp_p[0]  <= read_exp;
      cmp_addr_p[0] <= read_addr;
      for (int s = 1; s < LAT; s++) begin
        cmp_vld_p[s]  <= cmp_vld_p[s-1];
        cmp_exp_p[s]  <= cmp_exp_p[s-1];
        cmp_addr_p[s] <= cmp_addr_p[s-1];
      end
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: two instances (OUTPUT_REG=1 and 0) each paired with a behavioural RAM,
// checked cycle by cycle against a reference of the write/read/done schedule.
module tb_ram_bist;

  localparam int DW   = 10;
  localparam int AW   = 12;
  localparam int NDUT = 2;
  localparam int AM   = 1 << AW;
  localparam int DM   = 1 << DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [DW-1:0] seed;

  logic          busy_v  [NDUT];
  logic          done_v  [NDUT];
  logic          pass_v  [NDUT];
  logic [15:0]   err_v   [NDUT];
  logic [AW-1:0] fea_v   [NDUT];
  logic          rr_v    [NDUT];
  logic [AW-1:0] ra_v    [NDUT];
  logic [DW-1:0] rd_v    [NDUT];
  logic          wr_v    [NDUT];
  logic [AW-1:0] wa_v    [NDUT];
  logic [DW-1:0] wd_v    [NDUT];

  logic          corrupt_en;
  logic [AW-1:0] corrupt_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int OREG = (g == 0) ? 1 : 0;
    logic [DW-1:0] mem [AM];
    logic [DW-1:0] q1, q2;

    ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUTPUT_REG(OREG)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .num_words      (num_words),
      .seed           (seed),
      .busy           (busy_v[g]),
      .done           (done_v[g]),
      .pass           (pass_v[g]),
      .err_count      (err_v[g]),
      .first_err_addr (fea_v[g]),
      .read_req       (rr_v[g]),
      .read_addr      (ra_v[g]),
      .read_data      (rd_v[g]),
      .write_req      (wr_v[g]),
      .write_addr     (wa_v[g]),
      .write_data     (wd_v[g])
    );

    // Behavioural RAM: latency 1 from q1, latency 2 through the extra q2 register.
    always @(posedge clk) begin
      if (wr_v[g]) mem[wa_v[g]] <= wd_v[g];
      if (rr_v[g]) q1 <= (corrupt_en && ra_v[g] == corrupt_addr) ? '0 : mem[ra_v[g]];
      q2 <= q1;
    end
    assign rd_v[g] = (OREG != 0) ? q2 : q1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("%s d%0d busy", tag, g),       32'(busy_v[g]), 0);
      check($sformatf("%s d%0d done", tag, g),       32'(done_v[g]), 0);
      check($sformatf("%s d%0d write_req", tag, g),  32'(wr_v[g]), 0);
      check($sformatf("%s d%0d write_addr", tag, g), 32'(wa_v[g]), 0);
      check($sformatf("%s d%0d write_data", tag, g), 32'(wd_v[g]), 0);
      check($sformatf("%s d%0d read_req", tag, g),   32'(rr_v[g]), 0);
      check($sformatf("%s d%0d read_addr", tag, g),  32'(ra_v[g]), 0);
    end
  endtask

  // Runs one test and checks every output of both instances on every cycle of it.
  task automatic run_test(input int base, input int n, input int sd,
                          input bit repulse, input bit cor, input int cor_addr);
    int  done_rel [NDUT];
    int  exp_err, exp_fea, win;
    bit  exp_pass;
    bit  ew, er;
    int  ewa, ewd, era;
    string t;

    corrupt_en   = cor;
    corrupt_addr = AW'(cor_addr);
    exp_err = 0;
    exp_fea = 0;
    for (int i = 0; i < n; i++) begin
      if (cor && ((base + i) % AM) == cor_addr && ((sd + i) % DM) != 0) begin
        if (exp_err == 0) exp_fea = (base + i) % AM;
        exp_err++;
      end
    end
    exp_pass = (exp_err == 0);
    win = 0;
    for (int g = 0; g < NDUT; g++) begin
      done_rel[g] = (n == 0) ? 1 : 2 * n + ((g == 0) ? 2 : 1) + 1;
      if (done_rel[g] > win) win = done_rel[g];
    end

    @(negedge clk);
    base_addr = AW'(base);
    num_words = (AW + 1)'(n);
    seed      = DW'(sd);
    start     = 1'b1;
    for (int r = 1; r <= win + 2; r++) begin
      @(negedge clk);
      start = repulse && (r == n + 1);
      for (int g = 0; g < NDUT; g++) begin
        t   = $sformatf("b%0h n%0d d%0d r%0d", base, n, g, r);
        ew  = (r <= n);
        er  = (r > n) && (r <= 2 * n);
        ewa = ew ? (base + r - 1) % AM : 0;
        ewd = ew ? (sd + r - 1) % DM : 0;
        era = er ? (base + r - n - 1) % AM : 0;
        check({t, " write_req"},  32'(wr_v[g]), 32'(ew));
        check({t, " write_addr"}, 32'(wa_v[g]), ewa);
        check({t, " write_data"}, 32'(wd_v[g]), ewd);
        check({t, " read_req"},   32'(rr_v[g]), 32'(er));
        check({t, " read_addr"},  32'(ra_v[g]), era);
        check({t, " done"},       32'(done_v[g]), 32'(r == done_rel[g]));
        check({t, " busy"},       32'(busy_v[g]), 32'(r <= done_rel[g]));
        if (r < done_rel[g]) begin
          check({t, " pass_cleared"}, 32'(pass_v[g]), 0);
        end else begin
          check({t, " pass"},           32'(pass_v[g]), 32'(exp_pass));
          check({t, " err_count"},      32'(err_v[g]), exp_err);
          check({t, " first_err_addr"}, 32'(fea_v[g]), exp_fea);
        end
      end
    end
    corrupt_en = 1'b0;
  endtask

  initial begin
    int b, n, s, ca;
    bit c;

    reset        = 1'b1;
    start        = 1'b0;
    base_addr    = '0;
    num_words    = '0;
    seed         = '0;
    corrupt_en   = 1'b0;
    corrupt_addr = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("reset d%0d pass", g),      32'(pass_v[g]), 0);
      check($sformatf("reset d%0d err_count", g), 32'(err_v[g]), 0);
      check($sformatf("reset d%0d fea", g),       32'(fea_v[g]), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    run_test(5, 4, 'h00F, 1'b0, 1'b0, 0);
    run_test('hFFE, 4, 'h3FE, 1'b0, 1'b0, 0);
    run_test(5, 4, 'h00F, 1'b0, 1'b1, 7);
    run_test(5, 0, 'h00F, 1'b0, 1'b0, 0);

    // Asynchronous abort in the second write cycle.
    @(negedge clk);
    base_addr = 12'h100;
    num_words = 13'd4;
    seed      = 10'h055;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      check($sformatf("abort d%0d write_req before", g), 32'(wr_v[g]), 1);
    #2 reset = 1'b1;
    #1 check_quiet("abort");
    @(negedge clk);
    reset = 1'b0;
    repeat (14) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        check($sformatf("post-abort d%0d done", g), 32'(done_v[g]), 0);
        check($sformatf("post-abort d%0d busy", g), 32'(busy_v[g]), 0);
      end
    end
    run_test('h200, 2, 'h1A0, 1'b0, 1'b0, 0);

    run_test(5, 4, 'h00F, 1'b1, 1'b0, 0);

    for (int k = 0; k < 10; k++) begin
      b  = int'($urandom_range(0, AM - 1));
      n  = int'($urandom_range(1, 40));
      s  = int'($urandom_range(0, DM - 1));
      c  = 1'($urandom_range(0, 1));
      ca = (b + int'($urandom_range(0, n - 1))) % AM;
      run_test(b, n, s, 1'b0, c, ca);
    end

    run_test('h123, AM, 'h2AA, 1'b0, 1'b1, 'h456);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 10, RAM word width.
- ADDR_WIDTH, 12, RAM address width.
- OUTPUT_REG, 1, RAM output register present; read latency LAT = 1 + OUTPUT_REG cycles.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, begin test; sampled in IDLE only.
- base_addr, in, ADDR_WIDTH, first test address.
- num_words, in, ADDR_WIDTH+1, word count N.
- seed, in, DATA_WIDTH, pattern seed.
- busy, out, 1, test in progress.
- done, out, 1, one-cycle completion pulse.
- pass, out, 1, last test had zero mismatches.
- err_count, out, 16, mismatch count.
- first_err_addr, out, ADDR_WIDTH, address of the first mismatch.
- read_req, out, 1, RAM read request.
- read_addr, out, ADDR_WIDTH, RAM read address.
- read_data, in, DATA_WIDTH, RAM read data.
- write_req, out, 1, RAM write request.
- write_addr, out, ADDR_WIDTH, RAM write address.
- write_data, out, DATA_WIDTH, RAM write data.

REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high; the clock is named clk and the reset is named reset.

Function
REQ-004 FSM states are IDLE, WRITE, READ, DRAIN and DONE.
REQ-005 IDLE transitions on start=1:
- N>0: go to WRITE.
- N=0: go to DONE.
- In both cases, latch base_addr, num_words and seed, and clear err_count, first_err_addr and pass.
REQ-006 WRITE runs for N cycles, offset i = 0..N-1:
- write_req=1.
- write_addr = (base+i) mod 2^ADDR_WIDTH.
- write_data = (seed+i) mod 2^DATA_WIDTH.
REQ-007 WRITE goes directly to READ with no idle cycle.
REQ-008 READ runs for N cycles:
- read_req=1.
- read_addr = (base+i) mod 2^ADDR_WIDTH.
- Expected value and address for each read are pushed into a LAT-deep valid/expect/addr pipeline.
REQ-009 A read issued in cycle t is compared against read_data in cycle t+LAT.
REQ-010 On a mismatch:
- err_count increments, saturating at 16'hFFFF.
- first_err_addr is captured only on the first mismatch of the test.
REQ-011 DRAIN lasts LAT cycles, then goes to DONE.
REQ-012 DONE lasts one cycle:
- done=1.
- pass = (err_count==0), including any final-cycle mismatch.
- Return to IDLE.
REQ-013 Timing: with start sampled at edge k and N>0:
- Writes occur in cycles k+1..k+N.
- Reads occur in cycles k+N+1..k+2N.
- done occurs in cycle k+2N+LAT+1.
- With N=0, done occurs in cycle k+1 with no RAM requests.
REQ-014 busy=1 in WRITE, READ, DRAIN and DONE; busy=0 in IDLE.
REQ-015 start is ignored while busy=1.
REQ-016 read_req and write_req are never both 1 in the same cycle.
REQ-017 When a request is 0, its address and data outputs are 0.
REQ-018 pass, err_count and first_err_addr hold their values after DONE until the next accepted start.
REQ-019 All outputs are driven from registers.
REQ-020 N = 2^ADDR_WIDTH covers every address exactly once.

Reset
REQ-021 While reset=1:
- State is IDLE.
- busy, done, pass, read_req and write_req are 0.
- All address, data, err_count and first_err_addr outputs are 0.
- The compare pipeline is cleared.
REQ-022 Reset asserted mid-test aborts the test immediately, with no done pulse.
REQ-023 After reset releases, the first start runs a full clean test.

Verification
REQ-024 The bench pairs the block with a behavioural RAM of latency LAT, and covers these directed scenarios:
- OUTPUT_REG=1, base=5, N=4, seed=0x00F -> writes 5..8 with 0x00F..0x012; reads 5..8; done 4+4+2+1=11 cycles after start; pass=1; err_count=0.
- base=0xFFE, N=4, seed=0x3FE -> addresses FFE, FFF, 000, 001; data 3FE, 3FF, 000, 001; pass=1.
- Same as scenario 1, with the RAM returning 0x000 for address 7 -> err_count=1, first_err_addr=7, pass=0.
- N=0 -> done in the cycle after start; no read_req or write_req; pass=1.
- Reset pulsed during the second WRITE cycle -> write_req drops asynchronously; busy=0; no done. Then start with N=2 -> pass=1.
- start re-pulsed during READ -> ignored; exactly one done for the original test.
- OUTPUT_REG=0 rerun of scenario 1 -> done 4+4+1+1=10 cycles after start; pass=1.
